// File: rtl/ex_unit.sv
// EX stage: logic/shift ops, HI/LO moves, single-cycle multiply and an optional radix-2 divider.
// Define EX_DIVIDER_EN to build the DIV/DIVU divider; without it DIV/DIVU decode as unknown functs.
module ex_unit #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned SHAMT_W    = $clog2(DATA_W),
    parameter int unsigned FUNCT_W    = 6,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic [FUNCT_W-1:0]    funct,
    input  logic [DATA_W-1:0]     operand_1,
    input  logic [DATA_W-1:0]     operand_2,
    input  logic [SHAMT_W-1:0]    shamt,
    input  logic                  write_reg_en_in,
    input  logic [REG_ADDR_W-1:0] write_reg_addr_in,
    output logic [DATA_W-1:0]     result_out,
    output logic                  write_reg_en_out,
    output logic [REG_ADDR_W-1:0] write_reg_addr_out,
    output logic                  stall_req,
    output logic [DATA_W-1:0]     hi_out,
    output logic [DATA_W-1:0]     lo_out
);

    localparam logic [FUNCT_W-1:0] FUNCT_SLL   = FUNCT_W'(6'h00);
    localparam logic [FUNCT_W-1:0] FUNCT_SRL   = FUNCT_W'(6'h02);
    localparam logic [FUNCT_W-1:0] FUNCT_SRA   = FUNCT_W'(6'h03);
    localparam logic [FUNCT_W-1:0] FUNCT_SLLV  = FUNCT_W'(6'h04);
    localparam logic [FUNCT_W-1:0] FUNCT_SRLV  = FUNCT_W'(6'h06);
    localparam logic [FUNCT_W-1:0] FUNCT_SRAV  = FUNCT_W'(6'h07);
    localparam logic [FUNCT_W-1:0] FUNCT_MFHI  = FUNCT_W'(6'h10);
    localparam logic [FUNCT_W-1:0] FUNCT_MTHI  = FUNCT_W'(6'h11);
    localparam logic [FUNCT_W-1:0] FUNCT_MFLO  = FUNCT_W'(6'h12);
    localparam logic [FUNCT_W-1:0] FUNCT_MTLO  = FUNCT_W'(6'h13);
    localparam logic [FUNCT_W-1:0] FUNCT_MULT  = FUNCT_W'(6'h18);
    localparam logic [FUNCT_W-1:0] FUNCT_MULTU = FUNCT_W'(6'h19);
    localparam logic [FUNCT_W-1:0] FUNCT_AND   = FUNCT_W'(6'h24);
    localparam logic [FUNCT_W-1:0] FUNCT_OR    = FUNCT_W'(6'h25);
    localparam logic [FUNCT_W-1:0] FUNCT_XOR   = FUNCT_W'(6'h26);
    localparam logic [FUNCT_W-1:0] FUNCT_NOR   = FUNCT_W'(6'h27);

    logic [DATA_W-1:0]   hi_q, lo_q;
    logic [DATA_W-1:0]   alu_res;
    logic [SHAMT_W-1:0]  var_amt;
    logic [2*DATA_W-1:0] op1_sx, op2_sx, prod_s, prod_u;

    logic              div_stall;  // divider needs upstream held this cycle
    logic              div_wr;     // divider writes HI/LO at this edge
    logic              div_fn;     // funct is a divide (never writes the register file)
    logic [DATA_W-1:0] div_hi, div_lo;

    assign var_amt = operand_1[SHAMT_W-1:0];

    // Same-cycle logic, shift and move-from results
    always_comb begin
        alu_res = '0;
        case (funct)
            FUNCT_AND:  alu_res = operand_1 & operand_2;
            FUNCT_OR:   alu_res = operand_1 | operand_2;
            FUNCT_XOR:  alu_res = operand_1 ^ operand_2;
            FUNCT_NOR:  alu_res = ~(operand_1 | operand_2);
            FUNCT_SLL:  alu_res = operand_2 << shamt;
            FUNCT_SRL:  alu_res = operand_2 >> shamt;
            FUNCT_SRA:  alu_res = DATA_W'($signed(operand_2) >>> shamt);
            FUNCT_SLLV: alu_res = operand_2 << var_amt;
            FUNCT_SRLV: alu_res = operand_2 >> var_amt;
            FUNCT_SRAV: alu_res = DATA_W'($signed(operand_2) >>> var_amt);
            FUNCT_MFHI: alu_res = hi_q;
            FUNCT_MFLO: alu_res = lo_q;
            default:    alu_res = '0;
        endcase
    end

    // Low 2*DATA_W bits of the sign-extended product equal the signed product
    assign op1_sx = {{DATA_W{operand_1[DATA_W-1]}}, operand_1};
    assign op2_sx = {{DATA_W{operand_2[DATA_W-1]}}, operand_2};
    assign prod_s = op1_sx * op2_sx;
    assign prod_u = {{DATA_W{1'b0}}, operand_1} * {{DATA_W{1'b0}}, operand_2};

`ifdef EX_DIVIDER_EN
    localparam logic [FUNCT_W-1:0] FUNCT_DIV  = FUNCT_W'(6'h1A);
    localparam logic [FUNCT_W-1:0] FUNCT_DIVU = FUNCT_W'(6'h1B);
    localparam int unsigned        CNT_W      = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;

    div_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] quot_q, rem_q, dvsr_q;
    logic              neg_quot_q, neg_rem_q;
    logic              div_req, div_signed, op1_neg, op2_neg, trial_ok;
    logic [DATA_W-1:0] mag1, mag2;
    logic [DATA_W:0]   rem_shift, trial;

    assign div_fn     = (funct == FUNCT_DIV) || (funct == FUNCT_DIVU);
    assign div_req    = valid_in && div_fn;
    assign div_signed = (funct == FUNCT_DIV);
    assign op1_neg    = div_signed && operand_1[DATA_W-1];
    assign op2_neg    = div_signed && operand_2[DATA_W-1];
    assign mag1       = op1_neg ? (DATA_W'(0) - operand_1) : operand_1;
    assign mag2       = op2_neg ? (DATA_W'(0) - operand_2) : operand_2;

    // One restoring step: a set top bit of the trial difference means it went negative
    assign rem_shift  = {rem_q, quot_q[DATA_W-1]};
    assign trial      = rem_shift - {1'b0, dvsr_q};
    assign trial_ok   = ~trial[DATA_W];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= DIV_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            DIV_IDLE: if (div_req) state_d = (operand_2 == '0) ? DIV_DONE : DIV_BUSY;
            DIV_BUSY: if (cnt_q == CNT_W'(DATA_W - 1)) state_d = DIV_DONE;
            DIV_DONE: state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
    end

    always_comb begin
        div_stall = 1'b0;
        div_wr    = 1'b0;
        case (state_q)
            DIV_IDLE: div_stall = div_req;
            DIV_BUSY: div_stall = 1'b1;
            DIV_DONE: div_wr    = 1'b1;
            default:  ;
        endcase
    end

    // Divide by zero preloads the final LO/HI values with no sign fix pending
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            dvsr_q     <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (div_req) begin
                        cnt_q <= '0;
                        if (operand_2 == '0) begin
                            quot_q     <= '1;
                            rem_q      <= operand_1;
                            neg_quot_q <= 1'b0;
                            neg_rem_q  <= 1'b0;
                        end else begin
                            quot_q     <= mag1;
                            rem_q      <= '0;
                            dvsr_q     <= mag2;
                            neg_quot_q <= op1_neg ^ op2_neg;
                            neg_rem_q  <= op1_neg;
                        end
                    end
                end
                DIV_BUSY: begin
                    cnt_q  <= cnt_q + CNT_W'(1);
                    rem_q  <= trial_ok ? trial[DATA_W-1:0] : rem_shift[DATA_W-1:0];
                    quot_q <= {quot_q[DATA_W-2:0], trial_ok};
                end
                default: ;
            endcase
        end
    end

    assign div_lo = neg_quot_q ? (DATA_W'(0) - quot_q) : quot_q;
    assign div_hi = neg_rem_q  ? (DATA_W'(0) - rem_q)  : rem_q;
`else
    assign div_fn    = 1'b0;
    assign div_stall = 1'b0;
    assign div_wr    = 1'b0;
    assign div_hi    = '0;
    assign div_lo    = '0;
`endif

    // HI/LO: divider completion has priority; other writers only when not stalled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (div_wr) begin
            hi_q <= div_hi;
            lo_q <= div_lo;
        end else if (valid_in && !div_stall) begin
            case (funct)
                FUNCT_MTHI:  hi_q <= operand_1;
                FUNCT_MTLO:  lo_q <= operand_1;
                FUNCT_MULT:  {hi_q, lo_q} <= prod_s;
                FUNCT_MULTU: {hi_q, lo_q} <= prod_u;
                default:     ;
            endcase
        end
    end

    // Combinational outputs are forced to zero while reset is asserted
    assign stall_req          = rst && div_stall;
    assign result_out         = rst ? alu_res : '0;
    assign write_reg_en_out   = rst && valid_in && !div_stall && !div_fn && write_reg_en_in;
    assign write_reg_addr_out = (rst && valid_in && !div_stall) ? write_reg_addr_in : '0;
    assign hi_out             = hi_q;
    assign lo_out             = lo_q;

endmodule

// File: tb/tb_ex_unit.sv
// Testbench for ex_unit (DATA_W=32): directed corner cases plus randomized ops against an arithmetic model.
module tb_ex_unit;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned SHAMT_W    = 5;
    localparam int unsigned FUNCT_W    = 6;
    localparam int unsigned REG_ADDR_W = 5;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  valid_in;
    logic [FUNCT_W-1:0]    funct;
    logic [DATA_W-1:0]     operand_1, operand_2;
    logic [SHAMT_W-1:0]    shamt;
    logic                  write_reg_en_in;
    logic [REG_ADDR_W-1:0] write_reg_addr_in;
    logic [DATA_W-1:0]     result_out, hi_out, lo_out;
    logic                  write_reg_en_out, stall_req;
    logic [REG_ADDR_W-1:0] write_reg_addr_out;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] hi_m, lo_m;
    logic [5:0]  known [16] = '{6'h24, 6'h25, 6'h26, 6'h27, 6'h00, 6'h02, 6'h03, 6'h04,
                                6'h06, 6'h07, 6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19};

    ex_unit #(
        .DATA_W(DATA_W), .SHAMT_W(SHAMT_W), .FUNCT_W(FUNCT_W), .REG_ADDR_W(REG_ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .funct(funct),
        .operand_1(operand_1), .operand_2(operand_2), .shamt(shamt),
        .write_reg_en_in(write_reg_en_in), .write_reg_addr_in(write_reg_addr_in),
        .result_out(result_out), .write_reg_en_out(write_reg_en_out),
        .write_reg_addr_out(write_reg_addr_out), .stall_req(stall_req),
        .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic v, input logic wen, input logic [4:0] addr);
        funct = f; operand_1 = a; operand_2 = b; shamt = sh;
        valid_in = v; write_reg_en_in = wen; write_reg_addr_in = addr;
    endtask

    // Arithmetic shift right as a logical shift plus a sign mask
    function automatic logic [31:0] sra_ref(input logic [31:0] b, input logic [4:0] s);
        logic [31:0] ones;
        ones = 32'hFFFF_FFFF;
        return (b >> s) | (b[31] ? ~(ones >> s) : 32'h0);
    endfunction

    function automatic logic [31:0] model_result(input logic [5:0] f, input logic [31:0] a,
                                                  input logic [31:0] b, input logic [4:0] sh);
        case (f)
            6'h24: return a & b;
            6'h25: return a | b;
            6'h26: return a ^ b;
            6'h27: return ~(a | b);
            6'h00: return b << sh;
            6'h02: return b >> sh;
            6'h03: return sra_ref(b, sh);
            6'h04: return b << a[4:0];
            6'h06: return b >> a[4:0];
            6'h07: return sra_ref(b, a[4:0]);
            6'h10: return hi_m;
            6'h12: return lo_m;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_commit(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        longint          ps;
        longint unsigned pu;
        case (f)
            6'h11: hi_m = a;
            6'h13: lo_m = a;
            6'h18: begin
                ps = longint'($signed(a)) * longint'($signed(b));
                hi_m = ps[63:32]; lo_m = ps[31:0];
            end
            6'h19: begin
                pu = {32'h0, a} * {32'h0, b};
                hi_m = pu[63:32]; lo_m = pu[31:0];
            end
            default: ;
        endcase
    endtask

    task automatic div_model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] q, output logic [31:0] r);
        longint x, y, qq, rr;
        if (b == 32'h0) begin
            q = 32'hFFFF_FFFF; r = a;
        end else begin
            x = sgn ? longint'($signed(a)) : longint'({32'h0, a});
            y = sgn ? longint'($signed(b)) : longint'({32'h0, b});
            qq = x / y; rr = x % y;
            q = qq[31:0]; r = rr[31:0];
        end
    endtask

    // Presents a divide, counts stalled cycles, then checks HI/LO after the DONE edge
    task automatic run_div(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                           input int exp_stall, input string tag);
        int n;
        logic [31:0] q, r;
        @(negedge clk);
        drive(f, a, b, 5'd0, 1'b1, 1'b1, 5'd9);
        #1;
        n = 0;
        while (stall_req === 1'b1 && n < 200) begin
            chk({tag, " wen_stall"}, 32'(write_reg_en_out), 32'h0);
            n++;
            @(negedge clk); #1;
        end
        chk({tag, " stall_cycles"}, 32'(n), 32'(exp_stall));
        chk({tag, " wen_done"}, 32'(write_reg_en_out), 32'h0);
        chk({tag, " result_done"}, result_out, 32'h0);
        @(posedge clk); #1;
        div_model(f == 6'h1A, a, b, q, r);
        lo_m = q; hi_m = r;
        chk({tag, " lo"}, lo_out, lo_m);
        chk({tag, " hi"}, hi_out, hi_m);
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    initial begin
        logic [5:0]  f;
        logic [31:0] a, b, exp;
        logic [4:0]  sh, addr;
        logic        v, wen;
        int          n;

        // Reset holds all outputs at zero even with a live instruction on the inputs
        rst = 1'b0;
        drive(6'h24, 32'hF0F0_1234, 32'hFFFF_0000, 5'd3, 1'b1, 1'b1, 5'd7);
        hi_m = 32'h0; lo_m = 32'h0;
        #2;
        chk("rst result", result_out, 32'h0);
        chk("rst wen", 32'(write_reg_en_out), 32'h0);
        chk("rst waddr", 32'(write_reg_addr_out), 32'h0);
        chk("rst stall", 32'(stall_req), 32'h0);
        chk("rst hi", hi_out, 32'h0);
        chk("rst lo", lo_out, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        valid_in = 1'b0;

        // SRA sign fill, same cycle
        @(negedge clk);
        drive(6'h03, 32'h0, 32'h8000_0000, 5'd4, 1'b1, 1'b1, 5'd2);
        #1;
        chk("sra result", result_out, 32'hF800_0000);
        chk("sra wen", 32'(write_reg_en_out), 32'h1);
        chk("sra waddr", 32'(write_reg_addr_out), 32'h2);
        @(posedge clk); #1;

        // Signed multiply, HI/LO at the next edge, never stalls
        @(negedge clk);
        drive(6'h18, 32'hFFFF_FFFF, 32'h2, 5'd0, 1'b1, 1'b0, 5'd0);
        #1;
        chk("mult stall", 32'(stall_req), 32'h0);
        @(posedge clk); #1;
        chk("mult hi", hi_out, 32'hFFFF_FFFF);
        chk("mult lo", lo_out, 32'hFFFF_FFFE);
        chk("mult stall_after", 32'(stall_req), 32'h0);
        hi_m = 32'hFFFF_FFFF; lo_m = 32'hFFFF_FFFE;

        // Randomized non-divide ops, including unknown functs and idle cycles
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) f = 6'($urandom_range(0, 63));
            else                           f = known[$urandom_range(0, 15)];
`ifdef EX_DIVIDER_EN
            if (f == 6'h1A || f == 6'h1B) f = 6'h25;
`endif
            a = $urandom; b = $urandom; sh = 5'($urandom);
            v = ($urandom_range(0, 7) != 0); wen = 1'($urandom); addr = 5'($urandom);
            @(negedge clk);
            drive(f, a, b, sh, v, wen, addr);
            #1;
            exp = model_result(f, a, b, sh);
            if (v) chk($sformatf("rand result f=%h", f), result_out, exp);
            chk("rand wen", 32'(write_reg_en_out), 32'(v & wen));
            chk("rand waddr", 32'(write_reg_addr_out), v ? 32'(addr) : 32'h0);
            chk("rand stall", 32'(stall_req), 32'h0);
            @(posedge clk); #1;
            if (v) model_commit(f, a, b);
            chk($sformatf("rand hi f=%h", f), hi_out, hi_m);
            chk($sformatf("rand lo f=%h", f), lo_out, lo_m);
        end

`ifdef EX_DIVIDER_EN
        run_div(6'h1A, 32'hFFFF_FFF9, 32'h2, 33, "div -7/2");
        run_div(6'h1B, 32'd100, 32'h0, 1, "divu 100/0");
        run_div(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 33, "div min/-1");
        run_div(6'h1A, 32'd55, 32'h0, 1, "div 55/0");
        for (int i = 0; i < 6; i++) begin
            a = $urandom; b = (i == 3) ? 32'h0 : ($urandom >> $urandom_range(0, 28));
            if (b == 32'h0 && i != 3) b = 32'h7;
            run_div((i % 2 == 0) ? 6'h1A : 6'h1B, a, b, (b == 32'h0) ? 1 : 33, "div rand");
        end

        // Reset in the tenth BUSY cycle discards the divide
        @(negedge clk);
        drive(6'h1B, 32'd1000, 32'd7, 5'd0, 1'b1, 1'b0, 5'd0);
        #1;
        n = 0;
        while (stall_req === 1'b1 && n < 11) begin
            n++;
            if (n < 11) begin @(negedge clk); #1; end
        end
        chk("midrst reached", 32'(n), 32'd11);
        rst = 1'b0;
        #1;
        chk("midrst stall", 32'(stall_req), 32'h0);
        chk("midrst hi", hi_out, 32'h0);
        chk("midrst lo", lo_out, 32'h0);
        chk("midrst wen", 32'(write_reg_en_out), 32'h0);
        hi_m = 32'h0; lo_m = 32'h0;
        @(negedge clk);
        valid_in = 1'b0;
        rst = 1'b1;
        run_div(6'h1B, 32'd9, 32'd3, 33, "divu 9/3");
`else
        // Without the divider, divides behave as unknown functs
        for (int i = 0; i < 2; i++) begin
            f = (i == 0) ? 6'h1A : 6'h1B;
            @(negedge clk);
            drive(f, 32'd8, 32'd2, 5'd0, 1'b1, 1'b0, 5'd0);
            #1;
            chk("nodiv result", result_out, 32'h0);
            chk("nodiv stall", 32'(stall_req), 32'h0);
            @(posedge clk); #1;
            chk("nodiv stall_after", 32'(stall_req), 32'h0);
            chk("nodiv hi", hi_out, hi_m);
            chk("nodiv lo", lo_out, lo_m);
        end
`endif

        @(negedge clk);
        valid_in = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
